// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: walks the ROM sequentially, buffers fetched
// words in a small FIFO for decode, and handles redirects and end-of-ROM.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] ROM_LIMIT = 32'd400
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        done,
  output logic [15:0] flush_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam bit ResetDone = (RESET_PC >= ROM_LIMIT);

  typedef enum logic [0:0] {StFetch, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_fetch_pc, w_fetch_pc_next;
  logic [AW:0] r_count, w_count_next;
  logic [AW-1:0] r_head, w_head_next;
  logic [AW-1:0] r_tail, w_tail_next;
  logic [15:0] r_flush_count, w_flush_count_next;

  logic [31:0] r_mem_instr [DEPTH];
  logic [31:0] r_mem_pc    [DEPTH];

  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redir_pc;

  // Count never exceeds DEPTH (a power of two), so its MSB alone flags full.
  assign w_full     = r_count[AW];
  assign w_pc_plus4 = r_fetch_pc + 32'd4;
  assign w_redir_pc = redirect_pc & ~32'd3;

  // Outputs: reset overrides the registered values combinationally, since
  // the synchronous reset only takes effect at the next edge.
  always_comb begin
    rom_addr    = reset ? RESET_PC : r_fetch_pc;
    out_valid   = !reset && (r_count != '0);
    out_instr   = reset ? 32'd0 : r_mem_instr[r_head];
    out_pc      = reset ? 32'd0 : r_mem_pc[r_head];
    done        = reset ? ResetDone : (r_state == StDone);
    flush_count = r_flush_count;
  end

  // Next-state logic: redirect wins over push and pop.
  always_comb begin
    w_pop  = out_valid && out_ready && !redirect_valid;
    w_push = (r_state == StFetch) && !redirect_valid && (!w_full || w_pop);

    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_count_next       = r_count;
    w_head_next        = r_head;
    w_tail_next        = r_tail;
    w_flush_count_next = r_flush_count;

    if (redirect_valid) begin
      w_count_next    = '0;
      w_head_next     = '0;
      w_tail_next     = '0;
      w_fetch_pc_next = w_redir_pc;
      if (r_flush_count != 16'hFFFF) begin
        w_flush_count_next = r_flush_count + 16'd1;
      end
      if ((r_state == StDone) && (w_redir_pc < ROM_LIMIT)) begin
        w_state_next = StFetch;
      end
    end else begin
      if (w_push) begin
        w_tail_next     = r_tail + 1'b1;
        w_fetch_pc_next = w_pc_plus4;
        if (w_pc_plus4 >= ROM_LIMIT) begin
          w_state_next = StDone;
        end
      end
      if (w_pop) begin
        w_head_next = r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        w_count_next = r_count - 1'b1;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ResetDone ? StDone : StFetch;
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_flush_count <= 16'd0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_count       <= w_count_next;
      r_head        <= w_head_next;
      r_tail        <= w_tail_next;
      r_flush_count <= w_flush_count_next;
    end
  end

  // Queue storage write; contents need no reset as they are qualified by count.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem_instr[r_tail] <= rom_data;
      r_mem_pc[r_tail]    <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl: streaming, backpressure, redirect,
// end-of-ROM and mid-operation reset.
module tb_ifetch_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        done;
  logic [15:0] flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_ctrl #(
    .RESET_PC (32'd0),
    .DEPTH    (4),
    .ROM_LIMIT(32'd400)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .done          (done),
    .flush_count   (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM content: a distinct word per address.
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign rom_data = rom_f(rom_addr);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] e;

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_addr", rom_addr, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flush", {16'd0, flush_count}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);

    // Streaming
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_pc", out_pc, 32'(4 * i));
      check("stream_instr", out_instr, rom_f(32'(4 * i)));
    end

    // Backpressure
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("bp_addr", rom_addr, (k <= 4) ? 32'(4 * k) : 32'd16);
    end
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check("bp_pc", out_pc, 32'(4 * j));
      check("bp_instr", out_instr, rom_f(32'(4 * j)));
      tick();
    end

    // Redirect with a full queue, head offered with out_ready=1
    out_ready = 1'b0;
    tick();
    tick();
    check("full_addr", rom_addr, 32'd40);
    check("full_pc", out_pc, 32'd24);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h5E;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", {31'd0, out_valid}, 32'd0);
    check("redir_flush", {16'd0, flush_count}, 32'd1);
    check("redir_addr", rom_addr, 32'h5C);
    tick();
    check("redir_valid2", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h5C);
    check("redir_instr", out_instr, rom_f(32'h5C));

    // Run to the end of the ROM
    e = 32'h60;
    for (int n = 0; n < 200 && e <= 32'd396; n++) begin
      tick();
      check("eor_pc", out_pc, e);
      e = e + 32'd4;
    end
    check("eor_last", out_pc, 32'd396);
    check("eor_done", {31'd0, done}, 32'd1);
    tick();
    check("eor_drained", {31'd0, out_valid}, 32'd0);
    check("eor_addr", rom_addr, 32'd400);
    tick();
    tick();
    check("eor_idle", {31'd0, out_valid}, 32'd0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("far_done", {31'd0, done}, 32'd1);
    check("far_flush", {16'd0, flush_count}, 32'd2);
    check("far_addr", rom_addr, 32'h200);
    tick();
    check("far_valid", {31'd0, out_valid}, 32'd0);
    check("far_done2", {31'd0, done}, 32'd1);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h58;
    tick();
    redirect_valid = 1'b0;
    check("back_done", {31'd0, done}, 32'd0);
    check("back_flush", {16'd0, flush_count}, 32'd3);
    check("back_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("back_valid2", {31'd0, out_valid}, 32'd1);
    check("back_pc", out_pc, 32'h58);

    // Mid-operation reset with three entries queued and a redirect pending
    out_ready = 1'b0;
    tick();
    tick();
    check("mid_pc", out_pc, 32'h58);
    check("mid_addr", rom_addr, 32'h64);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_addr", rom_addr, 32'd0);
    tick();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_addr", rom_addr, 32'd0);
    check("post_flush", {16'd0, flush_count}, 32'd0);
    check("post_done", {31'd0, done}, 32'd0);
    tick();
    check("post_valid2", {31'd0, out_valid}, 32'd1);
    check("post_pc", out_pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
